// File: rtl/digital_clock_core.sv
// digital_clock_core
// MM:SS counter, 00:00 to MIN_MAX:SEC_MAX, advanced by an internal
// one-second tick derived from clk by a prescaler. All outputs are registered.
// reset is synchronous and active-high and takes priority over any tick.
module digital_clock_core #(
  parameter int unsigned TICKS_PER_SEC = 1,
  parameter int unsigned SEC_MAX       = 59,
  parameter int unsigned MIN_MAX       = 59
) (
  input  logic       clk,
  input  logic       reset,
  output logic [5:0] seconds,
  output logic [5:0] minutes,
  output logic       sec_tick,
  output logic       min_wrap
);

  logic       tick;
  logic       sec_last;
  logic       min_last;
  logic [5:0] seconds_d;
  logic [5:0] minutes_d;
  logic       wrap_d;

  generate
    if (TICKS_PER_SEC == 1) begin : g_no_prescale
      // Every clk is a second, so the tick never drops outside reset.
      assign tick = 1'b1;
    end else begin : g_prescale
      localparam logic [31:0] LAST = 32'(TICKS_PER_SEC - 1);
      logic [31:0] pre_cnt;

      // Prescaler runs 0..TICKS_PER_SEC-1 and restarts from 0 after reset.
      always_ff @(posedge clk) begin
        // NOTE: sequential state always uses non-blocking assignments so every
        // register samples the pre-edge values of the others.
        if (reset)                pre_cnt <= '0;
        else if (pre_cnt == LAST) pre_cnt <= '0;
        else                      pre_cnt <= pre_cnt + 32'd1;
      end

      assign tick = (pre_cnt == LAST);
    end
  endgenerate

  assign sec_last = (seconds == 6'(SEC_MAX));
  assign min_last = (minutes == 6'(MIN_MAX));

  // Next-count logic: seconds roll into minutes, minutes roll into a wrap pulse.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the if-chain can leave one unassigned and infer a latch.
    seconds_d = seconds;
    minutes_d = minutes;
    wrap_d    = 1'b0;
    if (tick) begin
      if (!sec_last) begin
        seconds_d = seconds + 6'd1;
      end else begin
        seconds_d = '0;
        if (!min_last) begin
          minutes_d = minutes + 6'd1;
        end else begin
          minutes_d = '0;
          wrap_d    = 1'b1;
        end
      end
    end
  end

  // Count and pulse registers; pulses line up with the edge that moves the count.
  always_ff @(posedge clk) begin
    if (reset) begin
      seconds  <= '0;
      minutes  <= '0;
      sec_tick <= 1'b0;
      min_wrap <= 1'b0;
    end else begin
      seconds  <= seconds_d;
      minutes  <= minutes_d;
      sec_tick <= tick;
      min_wrap <= wrap_d;
    end
  end

endmodule

// File: tb/tb_digital_clock_core.sv
// tb_digital_clock_core
// Two instances (TICKS_PER_SEC=1 and 4) share clk and reset. A model derives
// the expected MM:SS from the number of non-reset edges since the last reset
// edge; directed literal checks pin the model at the interesting points.
module tb_digital_clock_core;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] s1, m1, s4, m4;
  logic       t1, w1, t4, w4;

  int n_tests = 0;
  int n_fail  = 0;

  int edges       = 0;
  bit model_valid = 1'b0;

  digital_clock_core #(.TICKS_PER_SEC(1)) u1 (
    .clk(clk), .reset(reset), .seconds(s1), .minutes(m1),
    .sec_tick(t1), .min_wrap(w1)
  );

  digital_clock_core #(.TICKS_PER_SEC(4)) u4 (
    .clk(clk), .reset(reset), .seconds(s4), .minutes(m4),
    .sec_tick(t4), .min_wrap(w4)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int actual, input int expected);
    n_tests++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Model: elapsed non-reset edges since the most recent reset edge.
  always @(posedge clk) begin
    if (reset === 1'b1) begin
      edges       = 0;
      model_valid = 1'b1;
    end else begin
      edges = edges + 1;
    end
  end

  task automatic cmp(input string tag, input int tps, input logic [5:0] s,
                     input logic [5:0] m, input logic t, input logic w);
    int total;
    int exp_t;
    total = (edges / tps) % 3600;
    exp_t = (edges > 0 && (edges % tps) == 0) ? 1 : 0;
    check({tag, ".seconds"},  int'(s), total % 60);
    check({tag, ".minutes"},  int'(m), total / 60);
    check({tag, ".sec_tick"}, int'(t), exp_t);
    check({tag, ".min_wrap"}, int'(w), (exp_t == 1 && total == 0) ? 1 : 0);
  endtask

  // Compare both instances against the model every cycle, away from posedge.
  always @(negedge clk) begin
    if (model_valid) begin
      cmp("u1", 1, s1, m1, t1, w1);
      cmp("u4", 4, s4, m4, t4, w4);
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    step(3);
    check("rst_s1", int'(s1), 0);
    check("rst_m1", int'(m1), 0);
    check("rst_s4", int'(s4), 0);
    reset = 1'b0;

    step(1);                                   // 1 edge after release
    check("first_s1", int'(s1), 1);
    check("first_m1", int'(m1), 0);
    step(2);                                   // 3 edges
    check("u4_pre_s", int'(s4), 0);
    check("u4_pre_tick", int'(t4), 0);
    step(1);                                   // 4 edges
    check("u4_first_s", int'(s4), 1);
    check("u4_first_tick", int'(t4), 1);
    step(55);                                  // 59 edges
    check("e59_s1", int'(s1), 59);
    check("e59_m1", int'(m1), 0);
    step(1);                                   // 60 edges
    check("e60_s1", int'(s1), 0);
    check("e60_m1", int'(m1), 1);
    check("e60_tick", int'(t1), 1);
    check("e60_wrap", int'(w1), 0);
    step(180);                                 // 240 edges
    check("u4_e240_m", int'(m4), 1);
    check("u4_e240_s", int'(s4), 0);
    step(3359);                                // 3599 edges
    check("e3599_s1", int'(s1), 59);
    check("e3599_m1", int'(m1), 59);
    check("e3599_wrap", int'(w1), 0);
    step(1);                                   // 3600 edges
    check("e3600_s1", int'(s1), 0);
    check("e3600_m1", int'(m1), 0);
    check("e3600_wrap", int'(w1), 1);
    step(1);                                   // 3601 edges
    check("e3601_wrap", int'(w1), 0);
    check("e3601_s1", int'(s1), 1);

    // Restart, count to 12:34, then a one-cycle reset mid-count.
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    step(754);
    check("at1234_m", int'(m1), 12);
    check("at1234_s", int'(s1), 34);
    reset = 1'b1;
    step(1);
    check("mid_rst_s", int'(s1), 0);
    check("mid_rst_m", int'(m1), 0);
    reset = 1'b0;
    step(1);
    check("resume1_s", int'(s1), 1);
    step(1);
    check("resume2_s", int'(s1), 2);
    check("resume2_m", int'(m1), 0);

    // Long reset: outputs held at zero with no pulses on any edge.
    reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step(1);
      check("hold_s1", int'(s1), 0);
      check("hold_pulses", int'({t1, w1, t4, w4}), 0);
    end
    reset = 1'b0;
    step(4);
    check("post_hold_s4", int'(s4), 1);
    check("post_hold_s1", int'(s1), 4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/digital_clock_core.md
Name: digital_clock_core

Overview:
- Minutes:seconds time-of-day counter (MM:SS, 00:00 to 59:59) driven from a single system clock.
- An internal prescaler produces a one-cycle "second tick" every TICKS_PER_SEC clocks; each tick advances the count.
- Sits behind the clock interface bundle (clk, reset, seconds, minutes) and feeds display/monitor logic.
- Default TICKS_PER_SEC=1 (one second per clk) so simulation covers full wrap in 3600 cycles.

Parameters:
- TICKS_PER_SEC, 1, clk cycles per one-second increment; legal range 1 to 2^32-1.
- SEC_MAX, 59, last seconds value before wrap.
- MIN_MAX, 59, last minutes value before wrap.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- seconds  output  6  current seconds, binary, 0..SEC_MAX.
- minutes  output  6  current minutes, binary, 0..MIN_MAX.
- sec_tick  output  1  one-cycle pulse on the cycle seconds advances.
- min_wrap  output  1  one-cycle pulse on the cycle the count goes from MIN_MAX:SEC_MAX to 00:00.

Behaviour:
- Reset: sampled only at the rising clk edge. While reset=1 the next state is seconds=0, minutes=0, prescaler=0, sec_tick=0, min_wrap=0. Reset has priority over any tick.
- Prescaler: when TICKS_PER_SEC=1 the tick is constant 1 outside reset. Otherwise the counter runs 0..TICKS_PER_SEC-1 and produces the tick when it equals TICKS_PER_SEC-1, then returns to 0.
- Tick cycle, seconds below SEC_MAX: seconds increments by 1; minutes hold.
- Tick cycle, seconds = SEC_MAX and minutes below MIN_MAX: seconds goes to 0 and minutes increments by 1, both in the same edge.
- Tick cycle, seconds = SEC_MAX and minutes = MIN_MAX: seconds and minutes both go to 0, and min_wrap=1 for that cycle.
- No-tick cycle: outputs hold.
- Outputs are registered. With TICKS_PER_SEC=1:
  - The first edge after reset deasserts gives seconds=1.
  - After N edges with reset low, the count equals N mod 3600 expressed as MM:SS.
- sec_tick and min_wrap are registered and aligned with the edge that updates the counters.
- Values outside range cannot occur. No load or set input exists.
- Reset asserted mid-count: the count returns to 00:00 on the next edge and counting resumes from 0 after reset deasserts. No partial prescaler state is retained.
- No latches and no combinational path from input to output.

Test Plan:
- Apply reset for 3 cycles, then release → seconds=0 and minutes=0 during reset; seconds=1, minutes=0 one edge after release.
- Run 59 edges after release → seconds=59, minutes=0; next edge → seconds=0, minutes=1, sec_tick=1, min_wrap=0.
- Run 3599 edges after release → 59:59; next edge → 00:00 with min_wrap=1 for exactly one cycle.
- At count 12:34, assert reset for 1 cycle → 00:00 at the next edge; after release the count resumes 00:01, 00:02, and so on.
- With TICKS_PER_SEC=4 → seconds advances once every 4 clks; sec_tick is high 1 cycle in 4; after 240 clks minutes=1.
- Hold reset high across 10 edges → outputs stay 0 and no pulses occur.
